prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Host-side writer that downloads a program image into the CPU's 32x8 unified memory over a byte-stream valid/ready link.
- Holds the CPU in reset while the image is loaded, verifies an 8-bit checksum, then releases the CPU to fetch from address 0.
- Sits between the host/testbench byte source and the memory write port; it is the producer of the contents the CPU's fetch path consumes.

Parameters:
- DEPTH, 32, number of memory locations (addressable range 0..DEPTH-1).
- ADDR_W, 5, memory address width.
- DATA_W, 8, byte width of stream and memory.
- RST_HOLD, 4, cycles cpu_rst stays high after a good checksum before release (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a load; sampled only in IDLE, RUN or ERROR.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wr  out  1  one-cycle memory write strobe.
- cpu_rst  out  1  reset to CPU, active-high.
- busy  out  1  high in HDR, DATA, CSUM, HOLD.
- done  out  1  image loaded and CPU released.
- err  out  1  load failed.
- load_cnt  out  ADDR_W+1  number of data bytes written in the current or last load.

Behaviour:
- Reset values: state IDLE, in_ready 0, mem_addr 0, mem_wdata 0, mem_wr 0, cpu_rst 1, busy 0, done 0, err 0, load_cnt 0, sum 0. Reset mid-load aborts immediately; partially written memory is not cleared.
- All outputs are registered. A handshake is in_valid & in_ready at a rising edge.
- Frame format: one length byte N, then N data bytes, then one checksum byte equal to (sum of the N data bytes) mod 256.
- IDLE: in_ready 0. start -> HDR on the next cycle; clears done, err, load_cnt and sum.
- HDR: in_ready 1.
  - Accepted N with N==0 or N>DEPTH -> ERROR.
  - Otherwise latch N and go to DATA.
- DATA: in_ready 1.
  - Each accepted byte at index k (0-based): the next cycle shows mem_addr=k, mem_wdata=byte, mem_wr=1 for exactly one cycle.
  - sum updates as sum+byte mod 256; load_cnt becomes k+1.
  - Acceptance of byte N-1 -> CSUM.
- CSUM: in_ready 1.
  - Accepted byte equal to sum -> HOLD, with the hold counter loaded to RST_HOLD.
  - Mismatch -> ERROR.
- HOLD: in_ready 0, cpu_rst 1; the counter decrements each cycle. When the counter reaches 1 -> RUN. The final DATA write completes before HOLD, because the write lands in the CSUM cycle or earlier.
- RUN: cpu_rst 0, done 1, busy 0. start -> HDR with cpu_rst reasserted in the same transition cycle; done and err cleared.
- ERROR: err 1, cpu_rst 1, in_ready 0. Leaves only on start (-> HDR) or rst.
- cpu_rst is 1 in every state except RUN.
- in_valid gaps (bubbles) in any receiving state are legal: state holds, no write occurs.
- start in HDR, DATA, CSUM or HOLD is ignored.
- in_valid in a non-receiving state is ignored; no byte is consumed.
- Addresses never wrap: N <= DEPTH is guaranteed by the HDR check.

Test Plan:
- Normal load: pulse start, send 03, 11, 22, 33, 66 with in_valid continuous. Required:
  - three mem_wr pulses with addr/data 0/11, 1/22, 2/33;
  - load_cnt=3;
  - cpu_rst falls exactly RST_HOLD cycles after the checksum handshake;
  - done=1, err=0.
- Bad checksum: send 02, 01, 02, 04. Required: two writes, err=1, done=0, cpu_rst stays 1 for 20+ cycles, in_ready=0.
- Bad length: send 00, and separately 21 (33). Required: ERROR after the header, zero mem_wr pulses, load_cnt=0.
- Backpressure/bubbles: full 32-byte image (bytes 00..1F, checksum F0) with in_valid toggling randomly. Required:
  - exactly 32 writes at addresses 0..31 in order;
  - no duplicate or missed bytes;
  - done=1.
- Reset mid-load: assert rst after 2 of 5 data bytes. Required: outputs return to reset values asynchronously; cpu_rst=1; state IDLE; no further writes.
- Reload from RUN: after a good load, pulse start. Required: cpu_rst=1 and done=0 next cycle, in_ready=1; a second image loads correctly; start during DATA is ignored.

Source files
------------

// File: rtl/prog_loader.sv
// Program image loader: receives a length-prefixed, checksummed byte stream,
// writes it into CPU memory from address 0 and holds the CPU in reset until it verifies.
`timescale 1ns/1ps
module prog_loader #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   load_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_HOLD, S_RUN, S_ERROR
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [3:0]      HOLD_INIT = 4'(RST_HOLD);

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] sum;
  logic [3:0]        hold_cnt;
  logic              hs;
  logic              bad_len;

  assign hs = in_valid & in_ready;

  // A zero-length image or one larger than the memory is rejected at the header.
  always_comb bad_len = (in_data == '0) || (int'(in_data) > DEPTH);

  // NOTE: every register here uses non-blocking assignment so all branches see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_cnt  <= '0;
      sum       <= '0;
      len       <= '0;
      hold_cnt  <= '0;
    end else begin
      mem_wr <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            state    <= S_HDR;
            in_ready <= 1'b1;
            cpu_rst  <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            load_cnt <= '0;
            sum      <= '0;
          end
        end
        S_HDR: begin
          if (hs) begin
            if (bad_len) begin
              state    <= S_ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else begin
              state <= S_DATA;
              len   <= in_data[ADDR_W:0];
            end
          end
        end
        S_DATA: begin
          if (hs) begin
            mem_addr  <= load_cnt[ADDR_W-1:0];
            mem_wdata <= in_data;
            mem_wr    <= 1'b1;
            sum       <= sum + in_data;
            load_cnt  <= load_cnt + CNT_ONE;
            if (load_cnt + CNT_ONE == len) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (hs) begin
            in_ready <= 1'b0;
            if (in_data == sum) begin
              state    <= S_HOLD;
              hold_cnt <= HOLD_INIT;
            end else begin
              state <= S_ERROR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Release lands RST_HOLD edges after the checksum handshake.
          if (hold_cnt == 4'd1) begin
            state   <= S_RUN;
            busy    <= 1'b0;
            cpu_rst <= 1'b0;
            done    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames, hand sequences for timing
// corners, and random frames judged by a frame-level reference model.
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int DEPTH    = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 8;
  localparam int RST_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   load_cnt;

  prog_loader #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Every write strobe seen, as {addr, data}, sampled on the falling edge.
  logic [12:0] wr_q[$];
  always @(negedge clk) if (mem_wr === 1'b1) wr_q.push_back({mem_addr, mem_wdata});

  typedef struct {
    int             n;
    logic [0:5][7:0] b;
    bit             exp_done;
    bit             exp_err;
    int             exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it; in_valid stays high afterwards.
  task automatic send_byte(input logic [7:0] b, input bit bubbles);
    bit rdy;
    int waited;
    if (bubbles)
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    do begin
      rdy = in_ready;
      tick();
      waited++;
    end while (!rdy && waited < 100);
    if (!rdy) begin
      n_checks++;
      $display("FAIL handshake_timeout: in_ready stayed 0 for %0d cycles, expected a handshake", waited);
    end
  endtask

  // Load one frame from IDLE/RUN/ERROR and judge the outcome.
  task automatic run_frame(input string name, input logic [7:0] fr[$], input bit bubbles,
                           input bit exp_done, input bit exp_err, input int exp_cnt);
    int mism;
    bit rst_high;
    pulse_start();
    check({name, ".start_ready"}, 32'(in_ready), 1);
    check({name, ".start_cpu_rst"}, 32'(cpu_rst), 1);
    check({name, ".start_done"}, 32'(done), 0);
    wr_q.delete();
    foreach (fr[i]) send_byte(fr[i], bubbles);
    in_valid = 1'b0;
    rst_high = 1'b1;
    repeat (22) begin
      tick();
      if (cpu_rst !== 1'b1) rst_high = 1'b0;
    end
    check({name, ".done"}, 32'(done), 32'(exp_done));
    check({name, ".err"}, 32'(err), 32'(exp_err));
    check({name, ".load_cnt"}, 32'(load_cnt), exp_cnt);
    check({name, ".busy"}, 32'(busy), 0);
    check({name, ".in_ready"}, 32'(in_ready), 0);
    check({name, ".cpu_rst_held"}, 32'(rst_high), 32'(exp_err));
    check({name, ".wr_count"}, wr_q.size(), exp_cnt);
    mism = 0;
    foreach (wr_q[k])
      if (k < exp_cnt && k + 1 < fr.size() && wr_q[k] !== {5'(k), fr[k+1]}) mism++;
    check({name, ".wr_data"}, mism, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] img[4];
    int t, s, len, mism;
    bit good_len, exp_err;
    logic [7:0] csum;

    vecs[0] = '{5, {8'h03, 8'h11, 8'h22, 8'h33, 8'h66, 8'h00}, 1'b1, 1'b0, 3};
    vecs[1] = '{4, {8'h02, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00}, 1'b0, 1'b1, 2};
    vecs[2] = '{1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0};
    vecs[3] = '{1, {8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0};
    vecs[4] = '{3, {8'h01, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 1};
    vecs[5] = '{6, {8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0}, 1'b1, 1'b0, 4};
    vecs[6] = '{3, {8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 1};

    // Reset values
    repeat (3) tick();
    check("rst.in_ready", 32'(in_ready), 0);
    check("rst.mem_addr", 32'(mem_addr), 0);
    check("rst.mem_wdata", 32'(mem_wdata), 0);
    check("rst.mem_wr", 32'(mem_wr), 0);
    check("rst.cpu_rst", 32'(cpu_rst), 1);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.err", 32'(err), 0);
    check("rst.load_cnt", 32'(load_cnt), 0);
    rst = 1'b0;
    tick();

    // Normal load with exact release timing
    pulse_start();
    wr_q.delete();
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h66, 1'b0);
    check("normal.hold_busy", 32'(busy), 1);
    check("normal.hold_ready", 32'(in_ready), 0);
    check("normal.hold_cpu_rst", 32'(cpu_rst), 1);
    t = 0;
    do begin
      tick();
      t++;
    end while (cpu_rst === 1'b1 && t < 20);
    check("normal.release_cycles", t, RST_HOLD);
    in_valid = 1'b0;
    repeat (2) tick();
    check("normal.done", 32'(done), 1);
    check("normal.err", 32'(err), 0);
    check("normal.load_cnt", 32'(load_cnt), 3);
    check("normal.wr_count", wr_q.size(), 3);
    img = '{8'h11, 8'h22, 8'h33, 8'h00};
    mism = 0;
    foreach (wr_q[k]) if (k >= 3 || wr_q[k] !== {5'(k), img[k]}) mism++;
    check("normal.wr_data", mism, 0);

    // Reload from RUN, with start pulsed during DATA
    pulse_start();
    check("reload.cpu_rst", 32'(cpu_rst), 1);
    check("reload.done", 32'(done), 0);
    check("reload.in_ready", 32'(in_ready), 1);
    wr_q.delete();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_byte(8'h04, 1'b0);
    s = 0;
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);
      send_byte(img[i], 1'b0);
      start = 1'b0;
      s = (s + int'(img[i])) % 256;
    end
    send_byte(8'(s), 1'b0);
    in_valid = 1'b0;
    repeat (RST_HOLD + 3) tick();
    check("reload.done_after", 32'(done), 1);
    check("reload.err", 32'(err), 0);
    check("reload.load_cnt", 32'(load_cnt), 4);
    check("reload.wr_count", wr_q.size(), 4);
    mism = 0;
    foreach (wr_q[k]) if (k >= 4 || wr_q[k] !== {5'(k), img[k]}) mism++;
    check("reload.wr_data", mism, 0);

    // Table of frames
    foreach (vecs[v]) begin
      fr = {};
      for (int i = 0; i < vecs[v].n; i++) fr.push_back(vecs[v].b[i]);
      run_frame($sformatf("vec%0d", v), fr, 1'b0,
                vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_cnt);
    end

    // Full-depth image with random bubbles
    fr = {8'h20};
    for (int i = 0; i < 32; i++) fr.push_back(8'(i));
    fr.push_back(8'hF0);
    run_frame("full32", fr, 1'b1, 1'b1, 1'b0, 32);

    // Random frames against the frame-level model
    for (int f = 0; f < 15; f++) begin
      t = $urandom_range(0, 9);
      if (t == 0)      len = 0;
      else if (t == 1) len = $urandom_range(DEPTH + 1, 255);
      else             len = $urandom_range(1, DEPTH);
      good_len = (len >= 1) && (len <= DEPTH);
      fr = {8'(len)};
      s = 0;
      if (good_len) begin
        for (int i = 0; i < len; i++) begin
          fr.push_back(8'($urandom_range(0, 255)));
          s = (s + int'(fr[i+1])) % 256;
        end
        csum = 8'(s);
        if ($urandom_range(0, 3) == 0) csum = csum ^ 8'($urandom_range(1, 255));
        fr.push_back(csum);
      end
      exp_err = !good_len || (int'(fr[fr.size()-1]) != s);
      run_frame($sformatf("rand%0d", f), fr, 1'b1, !exp_err, exp_err, good_len ? len : 0);
    end

    // Reset in the middle of a load
    pulse_start();
    send_byte(8'h05, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst.in_ready", 32'(in_ready), 0);
    check("midrst.mem_wr", 32'(mem_wr), 0);
    check("midrst.mem_addr", 32'(mem_addr), 0);
    check("midrst.mem_wdata", 32'(mem_wdata), 0);
    check("midrst.cpu_rst", 32'(cpu_rst), 1);
    check("midrst.busy", 32'(busy), 0);
    check("midrst.done", 32'(done), 0);
    check("midrst.err", 32'(err), 0);
    check("midrst.load_cnt", 32'(load_cnt), 0);
    #2;
    rst = 1'b0;
    wr_q.delete();
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) tick();
    check("midrst.no_writes", wr_q.size(), 0);
    check("midrst.idle_ready", 32'(in_ready), 0);
    check("midrst.idle_busy", 32'(busy), 0);
    check("midrst.idle_cpu_rst", 32'(cpu_rst), 1);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
